// File: rtl/swd_seq_pkg.sv
// Shared types and constants for the SWD special-sequence generator.
// Includes the JTAG-to-SWD bit-pattern helper used when SWD_SEQ_J2S_EN is defined.
package swd_seq_pkg;

  typedef enum logic [1:0] {
    OP_LINE_RESET  = 2'd0,
    OP_IDLE_ZERO   = 2'd1,
    OP_JTAG_TO_SWD = 2'd2,
    OP_RAW         = 2'd3
  } swd_seq_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } swd_seq_state_t;

  localparam logic [15:0] SWD_J2S_KEY  = 16'hE79E;
  localparam logic [7:0]  SWD_J2S_PRE  = 8'd56;
  localparam logic [7:0]  SWD_J2S_POST = 8'd56;
  localparam logic [7:0]  SWD_J2S_IDLE = 8'd2;
  localparam logic [7:0]  SWD_J2S_LEN  = 8'd130;
  localparam logic [7:0]  SWD_RAW_MAX  = 8'd32;

  // Bit idx (0-based, in transmit order) of the 130-bit JTAG-to-SWD sequence.
  function automatic logic swd_j2s_bit(input logic [7:0] idx);
    logic [7:0] k;
    k = idx - SWD_J2S_PRE;
    if (idx < SWD_J2S_PRE) return 1'b1;
    if (idx < SWD_J2S_PRE + 8'd16) return SWD_J2S_KEY[k[3:0]];
    if (idx < SWD_J2S_PRE + 8'd16 + SWD_J2S_POST) return 1'b1;
    if (idx < SWD_J2S_LEN) return 1'b0;
    return 1'b0;
  endfunction

endpackage

// File: rtl/swd_clk_phase.sv
// Bit-phase timer: each SWD bit is CLK_DIV low cycles then CLK_DIV high cycles.
// Strobes decode the counter combinationally; the counter is held at zero while en is low.
module swd_clk_phase #(
  parameter int CLK_DIV = 1
) (
  input  logic sck,
  input  logic rst,
  input  logic en,
  output logic bit_start,
  output logic rise,
  output logic bit_end
);

  localparam int            CW   = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST)) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign bit_start = en && (cnt_q == '0);
  assign rise      = en && (cnt_q == HALF);
  assign bit_end   = en && (cnt_q == LAST);

endmodule

// File: rtl/swd_seq_gen.sv
// SWD special-sequence generator (line reset, idle zeros, JTAG-to-SWD, raw bits); outputs registered,
// first bit one cycle after accept; cmd_ready low while running. SWD_SEQ_J2S_EN builds the JTAG-to-SWD pattern.
module swd_seq_gen
  import swd_seq_pkg::*;
#(
  parameter int CLK_DIV = 1,
  parameter int LR_MIN  = 50
) (
  input  logic        sck,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_len,
  input  logic [31:0] raw_data,
  input  logic        abort,
  output logic        swclk,
  output logic        swdio_out,
  output logic        swdio_oe,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] LR_MIN_L = 8'(LR_MIN);

  swd_seq_state_t state_q, state_d;
  swd_seq_op_t    op_q, op_d;
  logic [7:0]     left_q, left_d;
  logic [31:0]    data_q, data_d;
  logic           swclk_q, swclk_d;
  logic           sdo_q, sdo_d;
  logic           oe_q, oe_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [7:0] len_eff;
  logic       cur_bit;
  logic       run;
  logic       bit_start, rise, bit_end;

  assign run = (state_q == ST_RUN);

  swd_clk_phase #(.CLK_DIV(CLK_DIV)) u_clk_phase (
    .sck       (sck),
    .rst       (rst),
    .en        (run),
    .bit_start (bit_start),
    .rise      (rise),
    .bit_end   (bit_end)
  );

  always_comb begin : len_calc
    len_eff = cmd_len;
    case (swd_seq_op_t'(cmd_op))
      OP_LINE_RESET:  len_eff = (cmd_len < LR_MIN_L) ? LR_MIN_L : cmd_len;
      OP_IDLE_ZERO:   len_eff = cmd_len;
      OP_JTAG_TO_SWD: begin
`ifdef SWD_SEQ_J2S_EN
        len_eff = SWD_J2S_LEN;
`else
        len_eff = '0;
`endif
      end
      OP_RAW:         len_eff = ((cmd_len == '0) || (cmd_len > SWD_RAW_MAX)) ? SWD_RAW_MAX : cmd_len;
    endcase
  end

  // left_q counts bits still to send, so the J2S index is LEN - left_q.
  always_comb begin : bit_sel
    cur_bit = 1'b0;
    case (op_q)
      OP_LINE_RESET:  cur_bit = 1'b1;
      OP_IDLE_ZERO:   cur_bit = 1'b0;
      OP_JTAG_TO_SWD: begin
`ifdef SWD_SEQ_J2S_EN
        cur_bit = swd_j2s_bit(SWD_J2S_LEN - left_q);
`else
        cur_bit = 1'b0;
`endif
      end
      OP_RAW:         cur_bit = data_q[0];
    endcase
  end

  always_comb begin : fsm
    state_d = state_q;
    op_d    = op_q;
    left_d  = left_q;
    data_d  = data_q;
    swclk_d = swclk_q;
    sdo_d   = sdo_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        swclk_d = 1'b0;
        oe_d    = 1'b0;
        if (cmd_valid) begin
          state_d = ST_RUN;
          op_d    = swd_seq_op_t'(cmd_op);
          left_d  = len_eff;
          data_d  = raw_data;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          swclk_d = 1'b0;
          oe_d    = 1'b0;
        end
`ifndef SWD_SEQ_J2S_EN
        else if (op_q == OP_JTAG_TO_SWD) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
        else if (bit_start) begin
          // A bit slot with nothing left to send closes the sequence.
          if (left_q == '0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            swclk_d = 1'b0;
            oe_d    = 1'b0;
          end else begin
            swclk_d = 1'b0;
            oe_d    = 1'b1;
            sdo_d   = cur_bit;
          end
        end else if (rise) begin
          swclk_d = 1'b1;
        end
        if (bit_end) begin
          left_d = left_q - 8'd1;
          data_d = {1'b0, data_q[31:1]};
        end
      end
    endcase
  end

  always_ff @(posedge sck or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LINE_RESET;
      left_q  <= '0;
      data_q  <= '0;
      swclk_q <= 1'b0;
      sdo_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      left_q  <= left_d;
      data_q  <= data_d;
      swclk_q <= swclk_d;
      sdo_q   <= sdo_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign swclk     = swclk_q;
  assign swdio_out = sdo_q;
  assign swdio_oe  = oe_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_swd_seq_gen.sv
// Directed bench for swd_seq_gen: instance 0 uses CLK_DIV=1, instance 1 uses CLK_DIV=2.
module tb_swd_seq_gen;

  localparam logic [1:0] LR  = 2'd0;
  localparam logic [1:0] IZ  = 2'd1;
  localparam logic [1:0] J2S = 2'd2;
  localparam logic [1:0] RAW = 2'd3;

  logic        sck = 1'b0;
  logic        rst = 1'b1;
  logic        cv    [2];
  logic [1:0]  op_i  [2];
  logic [7:0]  len_i [2];
  logic [31:0] dat_i [2];
  logic        ab_i  [2];
  logic        rdy_o [2];
  logic        clk_o [2];
  logic        sdo_o [2];
  logic        oe_o  [2];
  logic        done_o[2];
  logic        err_o [2];

  int checks   = 0;
  int failures = 0;

  always #5 sck = ~sck;

  swd_seq_gen #(.CLK_DIV(1), .LR_MIN(50)) dut0 (
    .sck(sck), .rst(rst), .cmd_valid(cv[0]), .cmd_ready(rdy_o[0]), .cmd_op(op_i[0]),
    .cmd_len(len_i[0]), .raw_data(dat_i[0]), .abort(ab_i[0]), .swclk(clk_o[0]),
    .swdio_out(sdo_o[0]), .swdio_oe(oe_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  swd_seq_gen #(.CLK_DIV(2), .LR_MIN(50)) dut1 (
    .sck(sck), .rst(rst), .cmd_valid(cv[1]), .cmd_ready(rdy_o[1]), .cmd_op(op_i[1]),
    .cmd_len(len_i[1]), .raw_data(dat_i[1]), .abort(ab_i[1]), .swclk(clk_o[1]),
    .swdio_out(sdo_o[1]), .swdio_oe(oe_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  // Called #1 after a rising edge; the next edge is the accept edge (cycle 0).
  task automatic issue(input int u, input logic [1:0] o, input logic [7:0] l,
                       input logic [31:0] d, input logic ab);
    cv[u] = 1'b1; op_i[u] = o; len_i[u] = l; dat_i[u] = d; ab_i[u] = ab;
    @(posedge sck); #1;
    cv[u] = 1'b0; ab_i[u] = 1'b0;
  endtask

  // Records swdio at each swclk rise and flags any rise off the expected cycle or with oe low.
  task automatic capture(input int u, input int limit, output int rises, output logic [159:0] bits,
                         output int done_c, output int err_c, output int bad_t,
                         output logic oe_end, output logic rdy_end);
    logic prev;
    int   dv;
    dv = (u == 0) ? 1 : 2;
    rises = 0; bits = '0; done_c = -1; err_c = -1; bad_t = 0; oe_end = 1'bx; rdy_end = 1'bx;
    prev = clk_o[u];
    for (int c = 1; c <= limit; c++) begin
      @(posedge sck); #1;
      if (clk_o[u] && !prev) begin
        if (rises < 160) bits[rises] = sdo_o[u];
        if (!oe_o[u] || (c != 1 + 2 * dv * rises + dv)) bad_t++;
        rises++;
      end
      prev = clk_o[u];
      if (done_o[u] || err_o[u]) begin
        if (done_o[u]) done_c = c;
        if (err_o[u])  err_c  = c;
        oe_end  = oe_o[u];
        rdy_end = rdy_o[u];
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({clk_o[u], sdo_o[u], oe_o[u], rdy_o[u], done_o[u], err_o[u]} !== 6'b000100) begin
        $display("FAIL reset_state u%0d got=%b exp=000100", u,
                 {clk_o[u], sdo_o[u], oe_o[u], rdy_o[u], done_o[u], err_o[u]});
        failures++;
      end
    end
  endtask

  task automatic test_line_reset();
    int r, dc, ec, bt; logic [159:0] b; logic oe_e, rdy_e;
    issue(0, LR, 8'd64, 32'h0, 1'b0);
    capture(0, 300, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 64 || dc !== 129 || ec !== -1 || bt !== 0) begin
      $display("FAIL lr64_timing rises=%0d done=%0d err=%0d bad=%0d exp 64/129/-1/0", r, dc, ec, bt);
      failures++;
    end
    checks++;
    if (b[63:0] !== {64{1'b1}}) begin
      $display("FAIL lr64_bits got=%h exp=ffffffffffffffff", b[63:0]); failures++;
    end
    checks++;
    if ({oe_e, rdy_e, sdo_o[0]} !== 3'b011) begin
      $display("FAIL lr64_end oe/rdy/sdo=%b exp=011", {oe_e, rdy_e, sdo_o[0]}); failures++;
    end
  endtask

  task automatic test_clamp_idle();
    int r, dc, ec, bt; logic [159:0] b; logic oe_e, rdy_e;
    issue(0, LR, 8'd10, 32'h0, 1'b0);
    capture(0, 300, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 50 || dc !== 101 || bt !== 0 || b[49:0] !== {50{1'b1}}) begin
      $display("FAIL lr_clamp rises=%0d done=%0d bad=%0d bits=%h exp 50/101/0/all ones", r, dc, bt, b[49:0]);
      failures++;
    end
    issue(0, IZ, 8'd50, 32'h0, 1'b0);
    capture(0, 300, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 50 || dc !== 101 || bt !== 0 || b[49:0] !== 50'h0) begin
      $display("FAIL iz50 rises=%0d done=%0d bad=%0d bits=%h exp 50/101/0/zeros", r, dc, bt, b[49:0]);
      failures++;
    end
    checks++;
    if (sdo_o[0] !== 1'b0) begin
      $display("FAIL iz50_hold swdio_out=%b exp=0", sdo_o[0]); failures++;
    end
    issue(0, IZ, 8'd0, 32'h0, 1'b0);
    capture(0, 20, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 0 || dc !== 1 || oe_e !== 1'b0) begin
      $display("FAIL iz0 rises=%0d done=%0d oe=%b exp 0/1/0", r, dc, oe_e); failures++;
    end
  endtask

  task automatic test_j2s();
    int r, dc, ec, bt; logic [159:0] b; logic oe_e, rdy_e;
    logic [129:0] exp_bits; logic [15:0] key;
    key = 16'hE79E;
    for (int i = 0; i < 130; i++) begin
      if (i < 56)       exp_bits[i] = 1'b1;
      else if (i < 72)  exp_bits[i] = key[i-56];
      else if (i < 128) exp_bits[i] = 1'b1;
      else              exp_bits[i] = 1'b0;
    end
    issue(1, J2S, 8'd0, 32'h0, 1'b0);
    capture(1, 700, r, b, dc, ec, bt, oe_e, rdy_e);
`ifdef SWD_SEQ_J2S_EN
    checks++;
    if (r !== 130 || dc !== 521 || ec !== -1 || bt !== 0) begin
      $display("FAIL j2s_timing rises=%0d done=%0d err=%0d bad=%0d exp 130/521/-1/0", r, dc, ec, bt);
      failures++;
    end
    checks++;
    if (b[129:0] !== exp_bits) begin
      $display("FAIL j2s_bits got=%h exp=%h", b[129:0], exp_bits); failures++;
    end
`else
    checks++;
    if (r !== 0 || ec !== 1 || dc !== -1 || rdy_e !== 1'b1 || exp_bits[60] !== 1'b1) begin
      $display("FAIL j2s_err rises=%0d err=%0d done=%0d rdy=%b exp 0/1/-1/1", r, ec, dc, rdy_e);
      failures++;
    end
`endif
  endtask

  task automatic test_raw();
    int r, dc, ec, bt; logic [159:0] b; logic oe_e, rdy_e;
    issue(0, RAW, 8'd8, 32'h0000_00A5, 1'b0);
    capture(0, 100, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 8 || dc !== 17 || bt !== 0 || b[7:0] !== 8'b1010_0101) begin
      $display("FAIL raw8 rises=%0d done=%0d bad=%0d bits=%b exp 8/17/0/10100101", r, dc, bt, b[7:0]);
      failures++;
    end
    issue(0, RAW, 8'd0, 32'hDEAD_BEEF, 1'b0);
    capture(0, 100, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 32 || dc !== 65 || bt !== 0 || b[31:0] !== 32'hDEAD_BEEF) begin
      $display("FAIL raw0 rises=%0d done=%0d bad=%0d bits=%h exp 32/65/0/deadbeef", r, dc, bt, b[31:0]);
      failures++;
    end
    issue(0, RAW, 8'd40, 32'h1234_5678, 1'b0);
    capture(0, 100, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 32 || dc !== 65 || b[31:0] !== 32'h1234_5678) begin
      $display("FAIL raw40 rises=%0d done=%0d bits=%h exp 32/65/12345678", r, dc, b[31:0]);
      failures++;
    end
  endtask

  task automatic test_abort();
    int r, dc, ec, bt; logic [159:0] b; logic oe_e, rdy_e; logic saw_done;
    issue(0, LR, 8'd64, 32'h0, 1'b0);
    repeat (41) begin @(posedge sck); #1; end
    checks++;
    if ({clk_o[0], oe_o[0], sdo_o[0]} !== 3'b011) begin
      $display("FAIL abort_pre clk/oe/sdo=%b exp=011", {clk_o[0], oe_o[0], sdo_o[0]}); failures++;
    end
    ab_i[0] = 1'b1;
    @(posedge sck); #1;
    ab_i[0] = 1'b0;
    checks++;
    if ({clk_o[0], oe_o[0], rdy_o[0], done_o[0]} !== 4'b0010) begin
      $display("FAIL abort_stop clk/oe/rdy/done=%b exp=0010", {clk_o[0], oe_o[0], rdy_o[0], done_o[0]});
      failures++;
    end
    saw_done = 1'b0;
    repeat (5) begin
      @(posedge sck); #1;
      if (done_o[0] || clk_o[0]) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      $display("FAIL abort_quiet activity=%b exp=0", saw_done); failures++;
    end
    issue(0, LR, 8'd64, 32'h0, 1'b0);
    capture(0, 300, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 64 || dc !== 129 || bt !== 0) begin
      $display("FAIL abort_rerun rises=%0d done=%0d bad=%0d exp 64/129/0", r, dc, bt); failures++;
    end
  endtask

  task automatic test_back_to_back();
    int r, dc, ec, bt; logic [159:0] b; logic oe_e, rdy_e;
    issue(0, RAW, 8'd8, 32'h0000_003C, 1'b1);
    capture(0, 100, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 8 || dc !== 17 || b[7:0] !== 8'h3C) begin
      $display("FAIL idle_abort_cmd rises=%0d done=%0d bits=%h exp 8/17/3c", r, dc, b[7:0]);
      failures++;
    end
    checks++;
    if ({oe_e, rdy_e} !== 2'b01) begin
      $display("FAIL b2b_gap oe/rdy=%b exp=01", {oe_e, rdy_e}); failures++;
    end
    issue(0, IZ, 8'd4, 32'h0, 1'b0);
    capture(0, 100, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 4 || dc !== 9 || bt !== 0 || b[3:0] !== 4'h0) begin
      $display("FAIL b2b_second rises=%0d done=%0d bad=%0d exp 4/9/0", r, dc, bt); failures++;
    end
  endtask

  task automatic test_reset_mid();
    int r, dc, ec, bt; logic [159:0] b; logic oe_e, rdy_e;
    issue(0, LR, 8'd64, 32'h0, 1'b0);
    repeat (30) begin @(posedge sck); #1; end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({clk_o[0], sdo_o[0], oe_o[0], rdy_o[0], done_o[0], err_o[0]} !== 6'b000100) begin
      $display("FAIL reset_mid got=%b exp=000100",
               {clk_o[0], sdo_o[0], oe_o[0], rdy_o[0], done_o[0], err_o[0]});
      failures++;
    end
    @(posedge sck); #1;
    rst = 1'b0;
    @(posedge sck); #1;
    issue(0, LR, 8'd50, 32'h0, 1'b0);
    capture(0, 300, r, b, dc, ec, bt, oe_e, rdy_e);
    checks++;
    if (r !== 50 || dc !== 101 || bt !== 0 || b[49:0] !== {50{1'b1}}) begin
      $display("FAIL reset_rerun rises=%0d done=%0d bad=%0d exp 50/101/0", r, dc, bt); failures++;
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      cv[u] = 1'b0; op_i[u] = 2'd0; len_i[u] = 8'd0; dat_i[u] = 32'd0; ab_i[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge sck);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge sck); #1;
    test_line_reset();
    test_clamp_idle();
    test_j2s();
    test_raw();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
